dmem_unit: RTL and testbench
============================

# dmem_unit

Data memory for the 4-stage pipeline. Accepts one load or store request per cycle from the decode stage (combinational address/data/enables) and returns load data registered, one cycle later, on the bus that stage 3 selects for load results. After reset it sweeps the whole array to zero, holds `mem_ready` low during the sweep, and flags misaligned or out-of-range accesses.

## Interface
Parameters:
- `DATA_WIDTH`, 64, word width in bits
- `ADDR_WIDTH`, 32, byte-address width from the pipeline
- `DEPTH`, 256, number of words (power of two, ≥ 2)

Ports:
- `clk`  input  1  single clock, all state on rising edge
- `rst`  input  1  asynchronous, active-low reset
- `mem_enable`  input  1  request valid this cycle
- `store_enable`  input  1  1 = store, 0 = load; meaningful only with `mem_enable`
- `dmem_address`  input  ADDR_WIDTH  byte address
- `dmem_dataIn`  input  DATA_WIDTH  store data
- `dmem_dataOut`  output  DATA_WIDTH  registered load data
- `mem_ready`  output  1  1 = initialization done, requests are serviced
- `addr_error`  output  1  registered one-cycle pulse for a rejected request

Reset is asynchronous and active-low (`rst` low = reset); there is one clock, `clk`.

## Operation
- Index is `IDX = dmem_address[3 +: log2(DEPTH)]`. Addresses are byte addresses and must be 8-byte aligned.
- A request is legal when `dmem_address[2:0]==0` and every address bit above the index field is 0.
- FSM states:
  - INIT (entered on reset): counter `clr_idx` starts at 0. Each cycle, write 0 to `mem[clr_idx]` and increment. When `clr_idx==DEPTH-1`, write the last word and go to READY. All requests in INIT are ignored: no write, `dmem_dataOut` unchanged, no `addr_error`.
  - READY: service requests. The FSM stays in READY until reset.
- READY, legal store: at the edge, `mem[IDX] <= dmem_dataIn`. `dmem_dataOut` holds its value.
- READY, legal load: at the edge, `dmem_dataOut <= mem[IDX]`. Data written by a store at the previous edge is visible.
- READY, illegal request: the store is suppressed and a load returns `dmem_dataOut <= 0`. `addr_error` is 1 for the following cycle.
- READY, `mem_enable==0`: no access; `dmem_dataOut` holds.
- `store_enable` with `mem_enable==0` is ignored.

## Timing
- Reset values:
  - `dmem_dataOut = 0`, `mem_ready = 0`, `addr_error = 0`
  - FSM = INIT, `clr_idx = 0`
  - The array is not reset asynchronously; the INIT sweep clears it.
- INIT takes exactly DEPTH cycles. `mem_ready` rises at the edge that writes word DEPTH-1. The first request is serviced in the cycle after `mem_ready` reads 1.
- Load latency is 1: a request presented in cycle N (stage 2) appears on `dmem_dataOut` after edge N and is consumed by stage 3 in cycle N+1.
- Back-to-back requests are allowed every cycle; there is no stall output. Load-after-store to the same address in consecutive cycles returns the new data.
- `addr_error` is asserted for exactly one cycle per illegal request. Consecutive illegal requests keep it high.
- Reset asserted mid-INIT or mid-operation:
  - Outputs go to reset values immediately (asynchronous).
  - When released, the sweep restarts at 0.
  - A store in flight at assertion is dropped.

## Structure
- Shared package `dmem_pkg`:
  - FSM state enum `{ST_INIT, ST_READY}`
  - `IDX_W = $clog2(DEPTH)`, `ALIGN_BITS = 3`
- One sub-module, `dmem_array`: single-port synchronous-write, synchronous-read RAM (`we`, `addr`, `wdata`, `rdata`).
- The top holds the FSM, clear counter, legality check, write-port mux (clear vs. store) and output registers.

## Test plan
- Reset then idle, DEPTH=256: `mem_ready` low for exactly 256 cycles then high. Loads of 0x0, 0x7F8 and 0x400 all return 0.
- Store 0xDEADBEEF_CAFEF00D to 0x10, then load 0x10 in the next cycle: `dmem_dataOut` = 0xDEADBEEF_CAFEF00D one cycle after the load. A load of 0x18 returns 0.
- Misaligned store 0x14 with data 0x1234: `addr_error` high for 1 cycle and no write. A later load of 0x10 returns the previous value. Out-of-range load 0x800 returns 0 with `addr_error` high.
- Requests during INIT (store 0x8 with data 0x55 at cycle 10): ignored, no error. After ready, load 0x8 returns 0.
- Assert `rst` low mid-stream after storing 0xAA at 0x20: outputs clear immediately and `mem_ready` drops. After release plus 256 cycles, load 0x20 returns 0.
- 100 random back-to-back legal loads/stores against a reference model: every load result matches, with no bubble needed.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the pipeline data memory.
package dmem_pkg;

  localparam int unsigned DEF_DEPTH  = 256;
  localparam int unsigned IDX_W      = $clog2(DEF_DEPTH);
  localparam int unsigned ALIGN_BITS = 3;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port RAM: synchronous write, synchronous read (read returns pre-write contents).
module dmem_array #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 256,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_unit.sv
// Data memory with post-reset clear sweep, 1-cycle load latency and address checking.
module dmem_unit
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_enable,
  input  logic                  store_enable,
  input  logic [ADDR_WIDTH-1:0] dmem_address,
  input  logic [DATA_WIDTH-1:0] dmem_dataIn,
  output logic [DATA_WIDTH-1:0] dmem_dataOut,
  output logic                  mem_ready,
  output logic                  addr_error
);

  localparam int unsigned IW = $clog2(DEPTH);

  dmem_state_e           state_q, state_d;
  logic [IW-1:0]         clr_idx;
  logic [IW-1:0]         idx;
  logic                  legal;
  logic                  we;
  logic [IW-1:0]         waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ld_ok;
  logic                  ld_bad;
  logic                  err_d;
  logic                  rd_q;
  logic [DATA_WIDTH-1:0] hold_q;

  assign idx   = dmem_address[ALIGN_BITS +: IW];
  assign legal = (dmem_address[ALIGN_BITS-1:0] == '0) &&
                 ((dmem_address >> (ALIGN_BITS + IW)) == '0);

  // Next state, write-port mux (clear sweep vs. store) and request classification
  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    waddr   = idx;
    wdata   = dmem_dataIn;
    ld_ok   = 1'b0;
    ld_bad  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_INIT: begin
        we    = 1'b1;
        waddr = clr_idx;
        wdata = '0;
        if (clr_idx == IW'(DEPTH - 1)) state_d = ST_READY;
      end
      ST_READY: begin
        if (mem_enable) begin
          if (!legal) begin
            err_d  = 1'b1;
            ld_bad = !store_enable;
          end else if (store_enable) begin
            we = 1'b1;
          end else begin
            ld_ok = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_INIT;
    else      state_q <= state_d;
  end

  // Output is the RAM read register right after a load, otherwise the held value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_idx    <= '0;
      rd_q       <= 1'b0;
      hold_q     <= '0;
      mem_ready  <= 1'b0;
      addr_error <= 1'b0;
    end else begin
      if (state_q == ST_INIT) clr_idx <= clr_idx + IW'(1);
      rd_q <= ld_ok;
      if (!ld_ok) hold_q <= ld_bad ? '0 : dmem_dataOut;
      mem_ready  <= (state_d == ST_READY);
      addr_error <= err_d;
    end
  end

  assign dmem_dataOut = rd_q ? rdata : hold_q;

  dmem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .addr (waddr),
    .wdata(wdata),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_dmem_unit.sv
// Randomized self-checking bench for dmem_unit against a word-array reference model.
module tb_dmem_unit;

  logic        clk;
  logic        rst;
  logic        mem_enable;
  logic        store_enable;
  logic [31:0] dmem_address;
  logic [63:0] dmem_dataIn;
  logic [63:0] dmem_dataOut;
  logic        mem_ready;
  logic        addr_error;

  int unsigned checks;
  int unsigned failures;
  int unsigned cyc;
  logic [63:0] ref_mem [256];
  logic [63:0] exp_out;
  logic        exp_err;

  dmem_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(256)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_enable  (mem_enable),
    .store_enable(store_enable),
    .dmem_address(dmem_address),
    .dmem_dataIn (dmem_dataIn),
    .dmem_dataOut(dmem_dataOut),
    .mem_ready   (mem_ready),
    .addr_error  (addr_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One request for one cycle; model applies the architectural rules afterwards
  task automatic req(input logic en, input logic st, input logic [31:0] a, input logic [63:0] d);
    logic       was_ready;
    logic       legal;
    logic [7:0] i;
    mem_enable   = en;
    store_enable = st;
    dmem_address = a;
    dmem_dataIn  = d;
    was_ready    = (cyc >= 256);
    @(posedge clk);
    #1;
    cyc++;
    legal   = (a % 8 == 0) && (a < 32'd2048);
    i       = 8'(a / 8);
    exp_err = 1'b0;
    if (was_ready && en) begin
      if (!legal) begin
        exp_err = 1'b1;
        if (!st) exp_out = '0;
      end else if (st) begin
        ref_mem[i] = d;
      end else begin
        exp_out = ref_mem[i];
      end
    end
    check("dout", dmem_dataOut, exp_out);
    check("err", 64'(addr_error), 64'(exp_err));
    check("ready", 64'(mem_ready), 64'(cyc >= 256));
    mem_enable   = 1'b0;
    store_enable = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    check("rst_dout", dmem_dataOut, 64'h0);
    check("rst_err", 64'(addr_error), 64'h0);
    check("rst_ready", 64'(mem_ready), 64'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
    exp_out = '0;
    exp_err = 1'b0;
    for (int k = 0; k < 256; k++) ref_mem[k] = '0;
  endtask

  task automatic idle_until_ready();
    while (cyc < 256) req(1'b0, 1'b0, 32'h0, 64'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [63:0] d;
    logic        st;
    checks       = 0;
    failures     = 0;
    cyc          = 0;
    mem_enable   = 1'b0;
    store_enable = 1'b0;
    dmem_address = '0;
    dmem_dataIn  = '0;
    exp_out      = '0;
    exp_err      = 1'b0;
    rst          = 1'b0;
    #2;
    apply_reset();

    // Sweep: a store at cycle 10 must be ignored; ready checked every cycle
    while (cyc < 10) req(1'b0, 1'b0, 32'h0, 64'h0);
    req(1'b1, 1'b1, 32'h8, 64'h55);
    idle_until_ready();
    req(1'b1, 1'b0, 32'h0, 64'h0);
    req(1'b1, 1'b0, 32'h7F8, 64'h0);
    req(1'b1, 1'b0, 32'h400, 64'h0);
    req(1'b1, 1'b0, 32'h8, 64'h0);

    // Store then load-after-store
    req(1'b1, 1'b1, 32'h10, 64'hDEADBEEF_CAFEF00D);
    req(1'b1, 1'b0, 32'h10, 64'h0);
    check("lat_dout", dmem_dataOut, 64'hDEADBEEF_CAFEF00D);
    req(1'b0, 1'b0, 32'h0, 64'h0);
    req(1'b1, 1'b0, 32'h18, 64'h0);

    // Illegal requests, including back-to-back errors
    req(1'b1, 1'b1, 32'h14, 64'h1234);
    req(1'b1, 1'b0, 32'h10, 64'h0);
    check("nowr_dout", dmem_dataOut, 64'hDEADBEEF_CAFEF00D);
    req(1'b1, 1'b0, 32'h800, 64'h0);
    req(1'b1, 1'b0, 32'h3, 64'h0);
    req(1'b1, 1'b1, 32'h8000_0010, 64'h77);
    req(1'b0, 1'b1, 32'h10, 64'h99);
    req(1'b1, 1'b0, 32'h10, 64'h0);

    // Random legal back-to-back traffic over a small address window
    for (int n = 0; n < 100; n++) begin
      a  = 32'($urandom_range(0, 15)) * 8;
      st = 1'($urandom_range(0, 1));
      d  = {$urandom, $urandom};
      req(1'b1, st, a, d);
    end

    // Random traffic with illegal requests and idle cycles mixed in
    for (int n = 0; n < 100; n++) begin
      case ($urandom_range(0, 9))
        0: a = 32'($urandom_range(0, 2047));
        1: a = 32'h800 + 32'($urandom_range(0, 255)) * 8;
        default: a = 32'($urandom_range(0, 255)) * 8;
      endcase
      st = 1'($urandom_range(0, 1));
      d  = {$urandom, $urandom};
      req(1'($urandom_range(0, 7) != 0), st, a, d);
    end

    // Mid-stream reset with data and an error pending
    req(1'b1, 1'b1, 32'h20, 64'hAA);
    req(1'b1, 1'b0, 32'h20, 64'h0);
    req(1'b1, 1'b1, 32'h21, 64'h1);
    check("pre_rst_err", 64'(addr_error), 64'h1);
    mem_enable   = 1'b1;
    store_enable = 1'b1;
    dmem_address = 32'h28;
    dmem_dataIn  = 64'hBB;
    #2;
    apply_reset();
    mem_enable   = 1'b0;
    store_enable = 1'b0;
    idle_until_ready();
    req(1'b1, 1'b0, 32'h20, 64'h0);
    req(1'b1, 1'b0, 32'h28, 64'h0);
    req(1'b1, 1'b0, 32'h10, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
